// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_loader_pkg: shared state encoding and sizing for the imem loader.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package imem_loader_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
  localparam int unsigned CHECKSUM_WIDTH     = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | byte_packer: little-endian byte-to-word assembly with word-complete flag.|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 byte_en,
  input  logic [7:0]           byte_data,
  output logic [DataWidth-1:0] word,
  output logic                 word_done
);

  localparam int BPW   = int'(bytes_per_word(DataWidth));
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

  logic [CNT_W-1:0]     count;
  logic [DataWidth-1:0] word_next;

  // Shifting in from the top leaves byte 0 in the low lane once the word fills.
  generate
    if (BPW > 1) begin : g_shift
      assign word_next = {byte_data, word[DataWidth-1:8]};
    end else begin : g_single
      assign word_next = byte_data;
    end
  endgenerate

  assign word_done = byte_en && (count == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
      word  <= '0;
    end else if (byte_en) begin
      word  <= word_next;
      count <= word_done ? '0 : count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_loader: streams bytes into instruction memory, holds core in reset. |
// | Optional check byte: IMEM_LOADER_CHECKSUM_EN. Rev 1.0                    |
// +-------------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Addr      = 8,
  parameter int Depth     = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [Addr:0]        load_len,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 mem_enable,
  output logic [Addr-1:0]      mem_address,
  output logic [DataWidth-1:0] mem_data,
  output logic                 busy,
  output logic                 done,
  output logic                 cpu_hold,
  output logic                 checksum_err
);

  localparam logic [Addr:0] MAX_WORDS = (Addr + 1)'(Depth);
  localparam logic [Addr:0] ONE_WORD  = (Addr + 1)'(1);

  state_t               state;
  logic [Addr:0]        remaining;
  logic [Addr-1:0]      index;
  logic [Addr:0]        word_count;
  logic                 accept;
  logic                 start_ok;
  logic                 pack_en;
  logic                 word_done;
  logic [DataWidth-1:0] packed_word;

  assign accept     = byte_valid && byte_ready;
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign pack_en    = accept && (state == ST_COLLECT);
  assign word_count = (load_len > MAX_WORDS) ? MAX_WORDS : load_len;

  byte_packer #(
    .DataWidth(DataWidth)
  ) u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (start_ok),
    .byte_en  (pack_en),
    .byte_data(byte_data),
    .word     (packed_word),
    .word_done(word_done)
  );

  assign mem_address = index;
  assign mem_data    = packed_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      index      <= '0;
      byte_ready <= 1'b0;
      mem_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            index <= '0;
            if (load_len == '0) begin
              state     <= ST_DONE;
              remaining <= '0;
              done      <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ST_COLLECT;
              remaining  <= word_count;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              cpu_hold   <= 1'b1;
            end
          end
        end

        ST_COLLECT: begin
          if (word_done) begin
            state      <= ST_WRITE;
            byte_ready <= 1'b0;
            mem_enable <= 1'b1;
          end
        end

        ST_WRITE: begin
          mem_enable <= 1'b0;
          remaining  <= remaining - ONE_WORD;
          // The index only advances when another word follows, so it never wraps.
          if (remaining > ONE_WORD) begin
            index      <= index + Addr'(1);
            state      <= ST_COLLECT;
            byte_ready <= 1'b1;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= ST_CHECK;
            byte_ready <= 1'b1;
`else
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_hold   <= 1'b0;
`endif
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            state      <= ST_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_hold   <= 1'b0;
          end
        end
`endif

        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
          mem_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] sum;
  logic                      sum_err;

  // Check byte is valid when it brings the running modulo-256 sum to zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum     <= '0;
      sum_err <= 1'b0;
    end else if (start_ok) begin
      sum     <= '0;
      sum_err <= 1'b0;
    end else if (pack_en) begin
      sum <= sum + byte_data;
    end else if (accept && (state == ST_CHECK)) begin
      sum_err <= (CHECKSUM_WIDTH'(sum + byte_data) != '0);
    end
  end

  assign checksum_err = sum_err;
`else
  assign checksum_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: scoreboard bench for imem_loader; memory writes are checked by a
// monitor against queued expectations. Define IMEM_LOADER_CHECKSUM_EN to add check bytes.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          start      = 1'b0;
  logic [AW:0]   load_len   = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data  = '0;
  logic          byte_ready;
  logic          mem_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic          done;
  logic          cpu_hold;
  logic          checksum_err;

  imem_loader #(
    .DataWidth(DW),
    .Addr     (AW),
    .Depth    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .load_len    (load_len),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .mem_enable  (mem_enable),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .busy        (busy),
    .done        (done),
    .cpu_hold    (cpu_hold),
    .checksum_err(checksum_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[$];
  int         checks = 0;
  int         failures = 0;
  int         writes = 0;
  int         cycle = 0;
  int         last_write_cycle = -10;
  logic       prev_en = 1'b0;
  logic [7:0] cks = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every write pulse must match the head of the queue.
  always @(negedge clk) begin
    if (mem_enable) begin
      exp_t e;
      writes++;
      checks++;
      if (prev_en) begin
        failures++;
        $display("FAIL mem_enable_width: enable high on consecutive cycles at address %0h", mem_address);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, none expected", mem_address, mem_data);
      end else begin
        e = exp_q.pop_front();
        if (mem_address !== e.addr || mem_data !== e.data) begin
          failures++;
          $display("FAIL mem_write: got addr=%0h data=%08h expected addr=%0h data=%08h",
                   mem_address, mem_data, e.addr, e.data);
        end
      end
      last_write_cycle = cycle;
    end
    prev_en = mem_enable;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_mem_enable"}, 64'(mem_enable), 64'd0);
    check({tag, "_mem_address"}, 64'(mem_address), 64'd0);
    check({tag, "_mem_data"}, 64'(mem_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_checksum_err"}, 64'(checksum_err), 64'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    src_q.push_back(b);
    cks = cks + b;
  endtask

  task automatic push_word(input int addr, input logic [DW-1:0] w);
    for (int k = 0; k < DW / 8; k++) push_byte(w[8*k +: 8]);
    exp_q.push_back('{addr: AW'(addr), data: w});
  endtask

  task automatic close_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    src_q.push_back(8'(-cks));
`endif
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    start    = 1'b1;
    load_len = (AW + 1)'(len);
    cks      = '0;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Presents queued bytes; a byte is retired when valid meets ready at the next edge.
  task automatic drive(input bit throttle);
    int  guard = 0;
    bit  phase = 1'b1;
    while (src_q.size() > 0 && guard < 6000) begin
      @(negedge clk);
      guard++;
      byte_valid = throttle ? phase : 1'b1;
      phase      = ~phase;
      byte_data  = src_q[0];
      if (byte_valid && byte_ready) void'(src_q.pop_front());
    end
    if (src_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout: %0d bytes left unaccepted", src_q.size());
      src_q.delete();
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit timed);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (timed) check({name, "_done_latency"}, 64'(cycle - last_write_cycle), 64'd1);
`endif
    check({name, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // Basic load
    do_start(2);
    check("basic_busy", 64'(busy), 64'd1);
    check("basic_byte_ready", 64'(byte_ready), 64'd1);
    check("basic_cpu_hold_loading", 64'(cpu_hold), 64'd1);
    check("basic_done_cleared", 64'(done), 64'd0);
    push_word(0, 32'h0000_0013);
    push_word(1, 32'h0010_0093);
    close_load();
    drive(1'b0);
    wait_done("basic", 1'b1);
    check("basic_checksum_err", 64'(checksum_err), 64'd0);

    // Throttled source
    w0 = writes;
    do_start(2);
    push_word(0, 32'h0000_0013);
    push_word(1, 32'h0010_0093);
    close_load();
    drive(1'b1);
    wait_done("throttled", 1'b1);
    check("throttled_write_count", 64'(writes - w0), 64'd2);

    // Clamp: 300 requested, 256 written, last address 255
    w0 = writes;
    do_start(300);
    for (int i = 0; i < DEPTH; i++) push_word(i, 32'hC0DE_0000 | 32'(i));
    close_load();
    drive(1'b0);
    wait_done("clamp", 1'b1);
    check("clamp_write_count", 64'(writes - w0), 64'd256);

    // Reset in the middle of word 1
    do_start(2);
    push_word(0, 32'h1122_3344);
    src_q.push_back(8'hA1);
    src_q.push_back(8'hA2);
    drive(1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    reset_n = 1'b1;
    check("midreset_queue", 64'(exp_q.size()), 64'd0);
    do_start(2);
    push_word(0, 32'hAABB_CCDD);
    push_word(1, 32'h0102_0304);
    close_load();
    drive(1'b0);
    wait_done("after_reset", 1'b1);

    // Zero-length load straight from reset
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    w0 = writes;
    do_start(0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_cpu_hold", 64'(cpu_hold), 64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_byte_ready", 64'(byte_ready), 64'd0);
    repeat (4) @(negedge clk);
    check("zero_no_writes", 64'(writes - w0), 64'd0);

    // start pulsed during COLLECT must be ignored
    do_start(3);
    push_word(0, 32'hDEAD_BEEF);
    drive(1'b0);
    @(negedge clk);
    start    = 1'b1;
    load_len = (AW + 1)'(1);
    @(negedge clk);
    start    = 1'b0;
    check("busy_start_ignored_busy", 64'(busy), 64'd1);
    check("busy_start_ignored_ready", 64'(byte_ready), 64'd1);
    push_word(1, 32'hCAFE_F00D);
    push_word(2, 32'h0BAD_C0DE);
    close_load();
    drive(1'b0);
    wait_done("busy_start", 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good check byte
    do_start(1);
    src_q.push_back(8'h13); src_q.push_back(8'h00); src_q.push_back(8'h00); src_q.push_back(8'h00);
    exp_q.push_back('{addr: AW'(0), data: 32'h0000_0013});
    src_q.push_back(8'hED);
    drive(1'b0);
    wait_done("cks_good", 1'b0);
    check("cks_good_err", 64'(checksum_err), 64'd0);

    // Bad check byte: memory still written, error flagged
    w0 = writes;
    do_start(1);
    src_q.push_back(8'h13); src_q.push_back(8'h00); src_q.push_back(8'h00); src_q.push_back(8'h00);
    exp_q.push_back('{addr: AW'(0), data: 32'h0000_0013});
    src_q.push_back(8'hEE);
    drive(1'b0);
    wait_done("cks_bad", 1'b0);
    check("cks_bad_err", 64'(checksum_err), 64'd1);
    check("cks_bad_written", 64'(writes - w0), 64'd1);
`else
    check("checksum_err_tied", 64'(checksum_err), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the single-cycle core's instruction memory from a byte stream (UART/debug bridge) before execution. It accepts bytes on a valid/ready handshake, packs them little-endian into words, and drives the instruction memory's write port (enable/address/data_in) one word at a time. While loading it holds the core in reset through `cpu_hold`, and it releases the core once the programmed word count has been written.

## Interface
- `DataWidth`, 32, word width; must be a multiple of 8 and match the instruction memory.
- `Addr`, 8, instruction memory address width.
- `Depth`, 256, number of instruction memory words.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; one clock, synchronous, active-low.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- `load_len`  in  Addr+1  number of words to load; latched when `start` is accepted.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_enable`  out  1  instruction memory write enable.
- `mem_address`  out  Addr  instruction memory word address.
- `mem_data`  out  DataWidth  instruction memory write data.
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed; level, held until the next accepted `start`.
- `cpu_hold`  out  1  core held in reset.
- `checksum_err`  out  1  checksum mismatch on the last load; see Configuration.

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (macro only), DONE.
- **IDLE/DONE → COLLECT** when `start`=1.
  - Latch `min(load_len, Depth)` as the word count.
  - Clear the word index, byte counter and checksum; clear `done` and `checksum_err`.
- **Zero-length start:** if `start`=1 with `load_len`=0, go directly to DONE.
- **Byte acceptance:** a byte is accepted on a rising edge where `byte_valid && byte_ready`.
  - `byte_ready`=1 only in COLLECT and CHECK.
  - Byte k (0..DataWidth/8−1) lands in bits [8k+7:8k].
- **COLLECT → WRITE** on acceptance of the last byte of a word.
- **WRITE** lasts exactly one cycle:
  - `mem_enable`=1, `mem_address`=index, `mem_data`=packed word.
  - Index then increments.
  - Next state is COLLECT if words remain, otherwise CHECK (macro defined) or DONE.
- **Address range:** the index never wraps; the clamp guarantees the last address is Depth−1.
- **DONE:** `done`=1 and `cpu_hold`=0.
- **`start` while busy** (COLLECT/WRITE/CHECK) is ignored.
- **`cpu_hold`** is 1 from reset and stays 1 until the first DONE.
  - It returns to 1 on any accepted `start`.
- **Reset** (any state, including mid-word): return to IDLE and discard the partial word; no memory write is issued.

## Timing
- Reset values:
  - `byte_ready`=0, `mem_enable`=0, `mem_address`=0, `mem_data`=0
  - `busy`=0, `done`=0, `cpu_hold`=1, `checksum_err`=0
- `start` accepted at edge N: `busy`=1 and `byte_ready`=1 from cycle N+1.
- Last byte of a word accepted at edge M:
  - `mem_enable`=1 during cycle M+1; the memory writes at edge M+2.
  - `byte_ready`=0 during that WRITE cycle.
- Peak throughput is one word per DataWidth/8+1 cycles.
- `done`=1 the cycle after the final WRITE (or after CHECK).
- All outputs are registered or decoded from state only. There is no combinational path from `byte_valid` to `byte_ready`.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit modulo-256 sum runs over all payload bytes.
  - After the last WRITE, CHECK accepts one extra byte and goes to DONE.
  - `checksum_err` is set if that byte ≠ two's-complement of the sum (sum + byte ≠ 0 mod 256).
  - Memory contents are written regardless of the checksum result.
- **Undefined:** no CHECK state, no extra byte, `checksum_err` tied to 0.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum type,
  - `BYTES_PER_WORD` = DataWidth/8,
  - the checksum width constant.
- Sub-module `byte_packer`: shift/assembly register with byte counter and word-complete flag, parameterised by DataWidth.

## Test plan
- **Basic load:** `load_len`=2, bytes 13 00 00 00 93 00 10 00 with `byte_valid` always high → writes 0x00000013 @0, then 0x00100093 @1; `done`=1 and `cpu_hold`=0 one cycle after the second write.
- **Throttled source:** `byte_valid` toggling every other cycle → same words and addresses; exactly 2 `mem_enable` pulses, each one cycle wide.
- **Clamp and zero length:**
  - `load_len`=300 with Depth=256 → last write at address 255, then DONE.
  - `load_len`=0 → DONE next cycle with no writes.
- **Reset mid-load:** `reset_n`=0 after 2 bytes of word 1 → all outputs at reset values; `start` 0x00 0x00 completes normally from address 0.
- **Checksum (macro defined):**
  - Payload 13 00 00 00 plus check byte 0xED → `checksum_err`=0.
  - Check byte 0xEE → `checksum_err`=1; memory is still written.
- **`start` pulsed during COLLECT** → ignored; word count and index are unchanged.
